// File: rtl/timer_disp_pkg.sv
// rtl/timer_disp_pkg.sv - shared types, sizes and helpers for the timer display front end
package timer_disp_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned BCD_W    = 4;
    localparam int unsigned DIGITS_W = N_DIGITS * BCD_W;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEL_W-1:0] sel_t;

    localparam bcd_t BCD_MAX = bcd_t'(9);

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic bcd_t digit_at(input logic [DIGITS_W-1:0] v, input sel_t s);
        bcd_t d;
        case (s)
            2'd0:    d = v[3:0];
            2'd1:    d = v[7:4];
            2'd2:    d = v[11:8];
            default: d = v[15:12];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot prescaler counting 0..DIV-1 with enable hold and wrap tick
module scan_prescaler #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap_o = en_i && (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The next-state count is exported so the parent can register outputs aligned with it.
    assign cnt_d_o = cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// rtl/bcd_scan_mux.sv - 4-digit BCD scan multiplexer with dead-time blanking and frame snapshot
// Optional feature: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_scan_mux
    import timer_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [DIGITS_W-1:0] DIGITS,
    output sel_t                SEL,
    output bcd_t                BCD,
    output logic                BLANK,
    output logic                FRAME
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, SCAN_HZ);
    localparam int unsigned CNT_W = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("bcd_scan_mux: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_blank
        $error("bcd_scan_mux: BLANK_CYCLES must lie in [1, DIV-1]");
    end

    logic [CNT_W-1:0]    cnt_d;
    logic                wrap;
    sel_t                sel_q, sel_d;
    logic [DIGITS_W-1:0] shadow_q, shadow_d;
    logic                primed_q, primed_d;
    logic                blank_q, blank_d;
    logic                frame_q, frame_d;
    bcd_t                nib_d;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (EN),
        .cnt_d_o (cnt_d),
        .wrap_o  (wrap)
    );

    // BLANK is computed from next-state values so it lines up with the slot SEL is entering.
    always_comb begin
        sel_d    = wrap ? sel_q + sel_t'(1) : sel_q;
        primed_d = primed_q | EN;
        frame_d  = wrap && (sel_q == sel_t'(3));
        shadow_d = shadow_q;
        if (EN && (!primed_q || frame_d)) begin
            shadow_d = DIGITS;
        end
        nib_d   = digit_at(shadow_d, sel_d);
        blank_d = !EN || !primed_d || (32'(cnt_d) < BLANK_CYCLES) || (nib_d > BCD_MAX);
`ifdef LEADING_ZERO_BLANK_EN
        case (sel_d)
            2'd3:    if (shadow_d[15:12] == '0) blank_d = 1'b1;
            2'd2:    if (shadow_d[15:8]  == '0) blank_d = 1'b1;
            2'd1:    if (shadow_d[15:4]  == '0) blank_d = 1'b1;
            default: ;
        endcase
`else
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q    <= '0;
            shadow_q <= '0;
            primed_q <= 1'b0;
            blank_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            primed_q <= primed_d;
            blank_q  <= blank_d;
            frame_q  <= frame_d;
        end
    end

    assign SEL   = sel_q;
    assign BCD   = digit_at(shadow_q, sel_q);
    assign BLANK = blank_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb/tb_bcd_scan_mux.sv - self-checking bench for bcd_scan_mux (DIV=4, BLANK_CYCLES=1)
module tb_bcd_scan_mux;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] DIGITS;
    logic [1:0]  SEL;
    logic [3:0]  BCD;
    logic        BLANK_O;
    logic        FRAME;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    bcd_scan_mux #(
        .CLK_HZ       (40),
        .SCAN_HZ      (10),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .DIGITS (DIGITS),
        .SEL    (SEL),
        .BCD    (BCD),
        .BLANK  (BLANK_O),
        .FRAME  (FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: everything derives from the number of enabled edges since reset.
    int          m_ticks;
    bit          m_primed;
    bit          m_en;
    bit          m_frame;
    logic [15:0] m_shadow;

    always @(posedge CLK) begin
        if (RST) begin
            m_ticks  <= 0;
            m_primed <= 1'b0;
            m_en     <= 1'b0;
            m_frame  <= 1'b0;
            m_shadow <= '0;
        end else begin
            m_en    <= EN;
            m_frame <= 1'b0;
            if (EN) begin
                m_ticks  <= m_ticks + 1;
                m_primed <= 1'b1;
                m_frame  <= ((m_ticks + 1) % (4 * DIV)) == 0;
                if (!m_primed || ((m_ticks + 1) % (4 * DIV)) == 0)
                    m_shadow <= DIGITS;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            int   e_sel;
            int   e_cnt;
            int   e_dig;
            logic e_blank;
            e_sel   = (m_ticks / DIV) % 4;
            e_cnt   = m_ticks % DIV;
            e_dig   = int'((m_shadow >> (4 * e_sel)) & 16'hF);
            e_blank = !m_en || !m_primed || (e_cnt < BLANK) || (e_dig > 9);
            if (LZB && e_sel > 0 && (m_shadow >> (4 * e_sel)) == 16'h0)
                e_blank = 1'b1;
            check("model_sel", 32'(SEL), 32'(e_sel));
            check("model_bcd", 32'(BCD), 32'(e_dig));
            check("model_blank", 32'(BLANK_O), 32'(e_blank));
            check("model_frame", 32'(FRAME), 32'(m_frame));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST    = 1'b1;
        EN     = 1'b0;
        DIGITS = 16'h1234;
        cyc(1);
        chk_on = 1'b1;
        cyc(2);
        check("rst_sel", 32'(SEL), 0);
        check("rst_bcd", 32'(BCD), 0);
        check("rst_blank", 32'(BLANK_O), 1);
        check("rst_frame", 32'(FRAME), 0);
        RST = 1'b0;
        EN  = 1'b1;

        cyc(1);   // ticks=1
        check("t1_sel", 32'(SEL), 0);
        check("t1_bcd", 32'(BCD), 4);
        check("t1_blank", 32'(BLANK_O), 0);
        cyc(3);   // ticks=4
        check("t4_sel", 32'(SEL), 1);
        check("t4_bcd", 32'(BCD), 3);
        check("t4_deadtime", 32'(BLANK_O), 1);
        cyc(1);   // ticks=5
        check("t5_blank", 32'(BLANK_O), 0);
        cyc(11);  // ticks=16
        check("t16_sel", 32'(SEL), 0);
        check("t16_frame", 32'(FRAME), 1);
        check("t16_bcd", 32'(BCD), 4);
        cyc(1);   // ticks=17
        check("t17_frame", 32'(FRAME), 0);

        cyc(3);   // ticks=20, SEL=1
        DIGITS = 16'h5678;
        cyc(1);
        check("tear_sel1", 32'(BCD), 3);
        cyc(3);
        check("tear_sel2", 32'(BCD), 2);
        cyc(4);
        check("tear_sel3", 32'(BCD), 1);
        cyc(4);   // ticks=32
        check("new_frame_bcd", 32'(BCD), 8);
        check("new_frame_pulse", 32'(FRAME), 1);
        cyc(4);
        check("new_frame_sel1", 32'(BCD), 7);

        cyc(5);   // ticks=41: SEL=2, cnt=1
        EN = 1'b0;
        cyc(1);
        check("hold_sel_a", 32'(SEL), 2);
        check("hold_blank_a", 32'(BLANK_O), 1);
        cyc(4);
        check("hold_sel_b", 32'(SEL), 2);
        check("hold_blank_b", 32'(BLANK_O), 1);
        EN = 1'b1;
        cyc(2);   // ticks=43
        check("resume_sel", 32'(SEL), 2);
        check("resume_blank", 32'(BLANK_O), 0);
        cyc(1);   // ticks=44
        check("resume_adv", 32'(SEL), 3);

        DIGITS = 16'h00A0;
        cyc(8);   // ticks=52, SEL=1 of the 00A0 frame
        for (int i = 0; i < 4; i++) begin
            check("inv_bcd", 32'(BCD), 32'hA);
            check("inv_blank", 32'(BLANK_O), 1);
            cyc(1);
        end
        check("inv_next_blank", 32'(BLANK_O), 1);
        check("inv_next_sel", 32'(SEL), 2);

        DIGITS = 16'h0050;
        cyc(9);   // ticks=65
        check("lz_d0_bcd", 32'(BCD), 0);
        check("lz_d0_blank", 32'(BLANK_O), 0);
        cyc(4);   // ticks=69
        check("lz_d1_bcd", 32'(BCD), 5);
        check("lz_d1_blank", 32'(BLANK_O), 0);
        cyc(4);   // ticks=73
        check("lz_d2_blank", 32'(BLANK_O), 32'(LZB));
        cyc(4);   // ticks=77
        check("lz_d3_sel", 32'(SEL), 3);
        check("lz_d3_blank", 32'(BLANK_O), 32'(LZB));

        RST = 1'b1;
        cyc(1);
        check("mid_rst_sel", 32'(SEL), 0);
        check("mid_rst_blank", 32'(BLANK_O), 1);
        check("mid_rst_frame", 32'(FRAME), 0);
        check("mid_rst_bcd", 32'(BCD), 0);
        RST = 1'b0;
        EN  = 1'b0;
        cyc(3);
        check("unprimed_blank", 32'(BLANK_O), 1);
        check("unprimed_sel", 32'(SEL), 0);
        EN = 1'b1;
        cyc(1);
        check("primed_blank", 32'(BLANK_O), 0);
        check("primed_bcd", 32'(BCD), 0);
        cyc(2);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
Time-multiplexing front end for the 4-digit seven-segment display. It sequences through the four BCD digits of the timer value at a fixed per-digit refresh rate.
- The 2-bit digit index feeds the 2-bit-to-one-hot anode decoder.
- The selected BCD nibble feeds the segment decoder.
- It also provides an anti-ghosting blank window at each digit change and a tear-free frame snapshot of the displayed value.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz
- SCAN_HZ, 1000, per-digit slot rate in Hz. DIV = CLK_HZ/SCAN_HZ; DIV >= 2 is required (elaboration-time assertion).
- BLANK_CYCLES, 1000, dead-time cycles at the start of each slot. Range is 1 <= BLANK_CYCLES < DIV (assertion).

Ports:
- CLK  input  1  system clock; one clock domain only
- RST  input  1  synchronous, active-high reset
- EN  input  1  scan enable; low freezes the scan and blanks the display
- DIGITS  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- SEL  output  2  current digit index, drives the one-hot anode decoder IN
- BCD  output  4  nibble of the current digit, taken from the shadow register
- BLANK  output  1  high = segments must be off
- FRAME  output  1  one-cycle pulse at each frame start (SEL 3->0)

Behaviour:
- Reset (RST high at a CLK edge): cnt=0, SEL=0, shadow=0, BCD=0, BLANK=1, FRAME=0, primed=0.
  - Reset asserted mid-operation takes effect at the next edge, whatever the state.
- Prescaler: cnt counts 0..DIV-1 while EN=1.
  - At cnt==DIV-1, cnt wraps to 0 and SEL increments modulo 4 (3->0).
  - While EN=0, cnt and SEL hold.
- Shadow load: shadow<=DIGITS on two events:
  - the first EN=1 cycle after reset (primed=0; primed is then set);
  - the edge where SEL wraps 3->0.
  - DIGITS changes at any other time are not visible until the next frame.
- BCD = shadow nibble indexed by SEL. It is a mux of registers; no extra latency relative to SEL.
- FRAME: registered. High for exactly the one cycle in which SEL first equals 0 after a 3->0 wrap.
  - It does not pulse after reset.
- BLANK (registered) = 1 if any of the following holds:
  - EN=0;
  - primed=0;
  - cnt < BLANK_CYCLES in the current slot;
  - the selected shadow nibble > 9 (invalid BCD). BCD still passes the raw nibble.
- Slot timing: each slot lasts DIV cycles, of which the first BLANK_CYCLES are blanked. A frame lasts 4*DIV cycles.
- EN deasserted mid-slot: the slot resumes at the held cnt when EN returns. BLANK follows the rules above on resume.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: for SEL=3, 2 or 1, BLANK is also forced high if the selected shadow digit and all more-significant shadow digits are 0. Digit 0 is never blanked by this rule.
- When undefined: zero digits display normally; only the base BLANK rules apply.

Decomposition:
- Package timer_disp_pkg holds:
  - N_DIGITS=4, SEL_W=2, BCD_W=4;
  - typedefs bcd_t (logic[3:0]) and sel_t (logic[1:0]);
  - function calc_div(clk_hz, scan_hz).
- Sub-module scan_prescaler (cnt, wrap tick, EN hold, sync reset) is natural and is instantiated once.

Test Plan (CLK_HZ=40, SCAN_HZ=10 -> DIV=4, BLANK_CYCLES=1):
1. RST high 3 cycles, then EN=1 -> SEL=0, BCD=0, BLANK=1, FRAME=0 during reset. After release, SEL holds each value 4 cycles in the order 0,1,2,3,0. FRAME pulses only on the 3->0 transition.
2. DIGITS=16'h1234 -> BCD shows 4,3,2,1 for SEL=0..3. BLANK=1 on cycle 0 of each slot and 0 on cycles 1-3.
3. Tear check: frame loaded with 16'h1234; DIGITS changed to 16'h5678 while SEL=1 -> remaining slots show 3,2,1. The next frame shows 8,7,6,5.
4. EN low for 5 cycles during SEL=2, cnt=1 -> SEL and cnt frozen, BLANK=1. On EN=1, SEL=2 continues from cnt=1 and advances to 3 after the remaining 3 cycles.
5. DIGITS=16'h00A0 -> during SEL=1, BCD=4'hA and BLANK=1 for all 4 cycles. Other slots behave normally.
6. DIGITS=16'h0050: with LEADING_ZERO_BLANK_EN, SEL=3 and SEL=2 are fully blanked, SEL=1 shows 5, SEL=0 shows 0. Without the macro, all digits are unblanked after the dead-time cycle.
